// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: EX->MEM two-entry skid register with Tnew decrement and flush.
// Define EX_MEM_OPERAND_REFRESH_EN to add writeback forwarding into buffered operands.
module ex_mem_skid_reg #(
  parameter int INSTR_W = 32,
  parameter int TNEW_W = 2,
  parameter int FLUSH_KEEP_SKID = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic [31:0]         in_reg1,
  input  logic [31:0]         in_reg2,
  input  logic [TNEW_W+36:0]  in_wd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [31:0]         out_reg1,
  output logic [31:0]         out_reg2,
  output logic [TNEW_W+36:0]  out_wd
`ifdef EX_MEM_OPERAND_REFRESH_EN
  ,
  input  logic                wb_we,
  input  logic [4:0]          wb_addr,
  input  logic [31:0]         wb_data,
  input  logic [4:0]          in_rs,
  input  logic [4:0]          in_rt
`endif
);
  localparam int WD_W = TNEW_W + 37;
`ifdef EX_MEM_OPERAND_REFRESH_EN
  localparam int X = 10;
`else
  localparam int X = 0;
`endif
  localparam int R2 = X + WD_W;
  localparam int R1 = R2 + 32;
  localparam int IN = R1 + 32;
  localparam int BW = IN + INSTR_W;
  // bundle layout, msb first: instr, reg1, reg2, wd{addr,data,tnew}, [rs, rt]
  logic [BW-1:0] main_q, main_d, skid_q, skid_d, in_r, main_r, skid_r;
  logic m_q, m_d, s_q, s_d, rdy_q, rdy_d, acc;
  logic [TNEW_W-1:0] tnew;
  logic [4:0] addr;
`ifdef EX_MEM_OPERAND_REFRESH_EN
  function automatic logic [BW-1:0] fresh(input logic [BW-1:0] b, input logic we,
                                          input logic [4:0] a, input logic [31:0] d);
    fresh = b;
    if (we && a != 5'd0 && a == b[9:5]) fresh[R1 +: 32] = d;
    if (we && a != 5'd0 && a == b[4:0]) fresh[R2 +: 32] = d;
  endfunction
`endif
  always_comb begin
    addr = in_wd[WD_W-1 -: 5];
    tnew = (addr == 5'd0 || in_wd[TNEW_W-1:0] == '0) ? '0 : in_wd[TNEW_W-1:0] - 1'b1;
`ifdef EX_MEM_OPERAND_REFRESH_EN
    in_r = fresh({in_instr, in_reg1, in_reg2, in_wd[WD_W-1:TNEW_W], tnew, in_rs, in_rt},
                 wb_we, wb_addr, wb_data);
    main_r = fresh(main_q, wb_we, wb_addr, wb_data);
    skid_r = fresh(skid_q, wb_we, wb_addr, wb_data);
`else
    in_r = {in_instr, in_reg1, in_reg2, in_wd[WD_W-1:TNEW_W], tnew};
    main_r = main_q;
    skid_r = skid_q;
`endif
  end
  always_comb begin
    acc = in_valid && rdy_q;
    m_d = m_q;
    s_d = s_q;
    main_d = main_r;
    skid_d = skid_r;
    if (flush) begin
      m_d = FLUSH_KEEP_SKID != 0 && s_q;
      main_d = m_d ? skid_r : '0;
      s_d = 1'b0;
      skid_d = '0;
    end else if (!m_q || out_ready) begin
      m_d = s_q || acc;
      main_d = s_q ? skid_r : acc ? in_r : main_r;
      s_d = 1'b0;
    end else if (acc) begin
      s_d = 1'b1;
      skid_d = in_r;
    end
    rdy_d = !s_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= 1'b0;
      s_q <= 1'b0;
      rdy_q <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
      rdy_q <= rdy_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  assign in_ready = rdy_q;
  assign out_valid = m_q;
  assign out_instr = main_q[BW-1:IN];
  assign out_reg1 = main_q[R1 +: 32];
  assign out_reg2 = main_q[R2 +: 32];
  assign out_wd = m_q ? main_q[X +: WD_W] : '0;
endmodule
